// File: rtl/ultrasonic_array.sv
// Multi-channel ultrasonic ranging controller: round-robin trigger, echo width
// measurement in prescaled units, per-channel result with timeout flag.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for start, ch held at 0
// S_TRIG      | trig[ch] high for TRIG_CYCLES cycles
// S_WAIT_ECHO | waiting for synchronised echo rise, WAIT_UNITS unit limit
// S_MEASURE   | counting units while echo high, saturates at MAX_UNITS
// S_REPORT    | one-cycle result_valid, result registers just loaded
// S_HOLD      | GAP_CYCLES holdoff before next channel / scan restart
module ultrasonic_array #(
  parameter int NCH         = 4,
  parameter int N           = 16,
  parameter int CONSTANT    = 588,
  parameter int TRIG_CYCLES = 500,
  parameter int WAIT_UNITS  = 50,
  parameter int MAX_UNITS   = 400,
  parameter int GAP_CYCLES  = 1000,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           continuous,
  input  logic [NCH-1:0] echo,
  output logic [NCH-1:0] trig,
  output logic           busy,
  output logic           result_valid,
  output logic [CW-1:0]  result_ch,
  output logic [N-1:0]   result_value,
  output logic           result_timeout
);

  localparam int PW   = $clog2(CONSTANT);
  localparam int TMAX = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int WW   = $clog2(WAIT_UNITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT_ECHO, S_MEASURE, S_REPORT, S_HOLD
  } state_t;

  state_t         state, state_nx;
  logic [NCH-1:0] echo_m, echo_s;
  logic [CW-1:0]  ch, ch_nx;
  logic [PW-1:0]  pre;
  logic [TW-1:0]  tmr, tmr_nx;
  logic [WW-1:0]  wait_cnt, wait_cnt_nx;
  logic [N-1:0]   value, value_nx;
  logic           ld_res;
  logic [N-1:0]   res_value_nx;
  logic           res_timeout_nx;
  logic           tick;
  logic           echo_sel;

  assign tick     = (pre == PW'(CONSTANT - 1));
  assign echo_sel = echo_s[ch];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      echo_m <= '0;
      echo_s <= '0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ch       <= '0;
      pre      <= '0;
      tmr      <= '0;
      wait_cnt <= '0;
      value    <= '0;
    end else begin
      state    <= state_nx;
      ch       <= ch_nx;
      tmr      <= tmr_nx;
      wait_cnt <= wait_cnt_nx;
      value    <= value_nx;
      // prescaler phase restarts on every state entry
      if (state_nx != state || tick) pre <= '0;
      else                            pre <= pre + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_ch      <= '0;
      result_value   <= '0;
      result_timeout <= 1'b0;
    end else if (ld_res) begin
      result_ch      <= ch;
      result_value   <= res_value_nx;
      result_timeout <= res_timeout_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    ch_nx          = ch;
    tmr_nx         = tmr;
    wait_cnt_nx    = wait_cnt;
    value_nx       = value;
    ld_res         = 1'b0;
    res_value_nx   = '0;
    res_timeout_nx = 1'b0;
    case (state)
      S_IDLE: begin
        ch_nx = '0;
        if (start) begin
          state_nx = S_TRIG;
          tmr_nx   = TW'(TRIG_CYCLES - 1);
        end
      end
      S_TRIG: begin
        if (tmr == '0) begin
          state_nx    = S_WAIT_ECHO;
          wait_cnt_nx = '0;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      S_WAIT_ECHO: begin
        if (echo_sel) begin
          state_nx = S_MEASURE;
          value_nx = '0;
        end else if (tick) begin
          if (wait_cnt == WW'(WAIT_UNITS - 1)) begin
            state_nx       = S_REPORT;
            ld_res         = 1'b1;
            res_timeout_nx = 1'b1;
          end else begin
            wait_cnt_nx = wait_cnt + 1'b1;
          end
        end
      end
      S_MEASURE: begin
        // saturation beats a simultaneous echo fall
        if (tick && value == N'(MAX_UNITS - 1)) begin
          state_nx       = S_REPORT;
          ld_res         = 1'b1;
          res_value_nx   = N'(MAX_UNITS);
          res_timeout_nx = 1'b1;
        end else if (!echo_sel) begin
          state_nx     = S_REPORT;
          ld_res       = 1'b1;
          res_value_nx = value + N'(tick);
        end else if (tick) begin
          value_nx = value + 1'b1;
        end
      end
      S_REPORT: begin
        state_nx = S_HOLD;
        tmr_nx   = TW'(GAP_CYCLES - 1);
      end
      S_HOLD: begin
        if (tmr == '0) begin
          if (ch != CW'(NCH - 1)) begin
            ch_nx    = ch + 1'b1;
            state_nx = S_TRIG;
            tmr_nx   = TW'(TRIG_CYCLES - 1);
          end else if (continuous) begin
            ch_nx    = '0;
            state_nx = S_TRIG;
            tmr_nx   = TW'(TRIG_CYCLES - 1);
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign trig         = (state == S_TRIG) ? (NCH'(1) << ch) : '0;
  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_REPORT);

endmodule

// File: tb/tb_ultrasonic_array.sv
// Self-checking bench for ultrasonic_array: arithmetic result/timing model fed
// by per-trigger echo scheduling, plus directed literal cases.
module tb_ultrasonic_array;
  localparam int NCH = 2, N = 16, C = 4, TRIG = 3, WAITU = 5, MAXU = 10, GAP = 2, CW = 1;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, continuous = 1'b0;
  logic [NCH-1:0] echo = '0;
  logic [NCH-1:0] trig;
  logic busy, result_valid, result_timeout;
  logic [CW-1:0] result_ch;
  logic [N-1:0] result_value;

  ultrasonic_array #(.NCH(NCH), .N(N), .CONSTANT(C), .TRIG_CYCLES(TRIG),
                     .WAIT_UNITS(WAITU), .MAX_UNITS(MAXU), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .echo(echo),
    .trig(trig), .busy(busy), .result_valid(result_valid), .result_ch(result_ch),
    .result_value(result_value), .result_timeout(result_timeout));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int ch; int value; int tmo; int at;} res_t;
  res_t exp_q[$];
  res_t log_q[$];
  int forced_d[$], forced_h[$];
  int tests = 0, fails = 0;
  int exp_rise_cyc = -1, exp_rise_ch = 0, idle_at = -1, last_rep = -1;
  bit decide_pending = 1'b0;
  int rise_at[NCH], fall_at[NCH], trig_up[NCH];
  logic [NCH-1:0] prev_trig = '0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Result from echo delay d (cycles after trig fall, <0 = none) and width h.
  function automatic res_t predict(int ch, int w, int d, int h);
    res_t r;
    r.ch = ch;
    if (d < 0 || d + 2 >= WAITU * C) begin
      r.value = 0; r.tmo = 1; r.at = w + WAITU * C;
    end else if (h / C >= MAXU) begin
      r.value = MAXU; r.tmo = 1; r.at = w + d + 3 + MAXU * C;
    end else begin
      r.value = h / C; r.tmo = 0; r.at = w + d + h + 3;
    end
    return r;
  endfunction

  // Model / driver / compare process
  initial begin
    int d, h;
    res_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        prev_trig = '0;
        echo = '0;
        exp_rise_cyc = -1;
        idle_at = -1;
        decide_pending = 1'b0;
        for (int i = 0; i < NCH; i++) begin rise_at[i] = 0; fall_at[i] = 0; end
      end else begin
        for (int i = 0; i < NCH; i++) begin
          if (trig[i] && !prev_trig[i]) begin
            trig_up[i] = cyc;
            chk("trig_rise_cycle", cyc, exp_rise_cyc);
            chk("trig_rise_ch", i, exp_rise_ch);
            exp_rise_cyc = -1;
          end
          if (!trig[i] && prev_trig[i]) begin
            chk("trig_width", cyc - trig_up[i], TRIG);
            if (forced_d.size() > 0) begin
              d = forced_d.pop_front();
              h = forced_h.pop_front();
            end else begin
              case ($urandom_range(0, 3))
                0:       begin d = -1; h = 0; end
                1:       begin d = $urandom_range(0, 12); h = $urandom_range(40, 44); end
                default: begin d = $urandom_range(0, 12); h = $urandom_range(1, 39); end
              endcase
            end
            if (d >= 0) begin rise_at[i] = cyc + d; fall_at[i] = cyc + d + h; end
            else begin rise_at[i] = 0; fall_at[i] = 0; end
            exp_q.push_back(predict(i, cyc, d, h));
          end
          echo[i] = (cyc >= rise_at[i]) && (cyc < fall_at[i]);
        end
        if (trig != '0) begin
          chk("trig_onehot", $onehot(trig), 1);
          chk("busy_in_trig", busy, 1);
        end
        if (exp_rise_cyc >= 0 && cyc > exp_rise_cyc) begin
          tests++; fails++;
          $display("FAIL trig_missing: no trig on ch %0d by cycle %0d", exp_rise_ch, exp_rise_cyc);
          exp_rise_cyc = -1;
        end
        if (exp_q.size() > 0 && cyc > exp_q[0].at) begin
          tests++; fails++;
          $display("FAIL result_missing: ch %0d expected at cycle %0d, none by %0d",
                   exp_q[0].ch, exp_q[0].at, cyc);
          void'(exp_q.pop_front());
        end
        if (result_valid) begin
          log_q.push_back(res_t'{int'(result_ch), int'(result_value), int'(result_timeout), cyc});
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_result: ch %0d value %0d at cycle %0d", result_ch, result_value, cyc);
          end else begin
            r = exp_q.pop_front();
            chk("result_ch", result_ch, r.ch);
            chk("result_value", result_value, r.value);
            chk("result_timeout", result_timeout, r.tmo);
            chk("result_cycle", cyc, r.at);
            if (r.ch != NCH - 1) begin
              exp_rise_cyc = cyc + GAP + 1;
              exp_rise_ch = r.ch + 1;
            end else begin
              last_rep = cyc;
              decide_pending = 1'b1;
            end
          end
        end
        if (decide_pending && cyc == last_rep + GAP) begin
          decide_pending = 1'b0;
          if (continuous) begin exp_rise_cyc = cyc + 1; exp_rise_ch = 0; end
          else idle_at = cyc + 1;
        end
        if (idle_at >= 0 && cyc == idle_at) begin
          chk("idle_after_scan", busy, 0);
          idle_at = -1;
        end
        prev_trig = trig;
      end
    end
  end

  task automatic start_scan();
    exp_rise_cyc = cyc + 1;
    exp_rise_ch = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_quiet(int lim);
    int n = 0;
    while ((busy || echo != '0) && n < lim) begin @(negedge clk); n++; end
    if (n >= lim) begin
      tests++; fails++;
      $display("FAIL wait_quiet: timed out, busy %0b", busy);
    end
  endtask

  task automatic chk_res(int idx, int ch, int v, int t);
    if (log_q.size() <= idx) begin
      tests++; fails++;
      $display("FAIL result_%0d: got none, expected ch %0d value %0d", idx, ch, v);
    end else begin
      chk($sformatf("lit%0d_ch", idx), log_q[idx].ch, ch);
      chk($sformatf("lit%0d_value", idx), log_q[idx].value, v);
      chk($sformatf("lit%0d_timeout", idx), log_q[idx].tmo, t);
    end
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_trig"}, trig, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, result_valid, 0);
    chk({tag, "_ch"}, result_ch, 0);
    chk({tag, "_value"}, result_value, 0);
    chk({tag, "_timeout"}, result_timeout, 0);
  endtask

  initial begin
    int n, rise0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // echo0 20 cycles, echo1 9 cycles
    log_q.delete();
    forced_d = {1, 1}; forced_h = {20, 9};
    start_scan();
    chk("trig0_first", trig, 1);
    chk("busy_first", busy, 1);
    repeat (2) @(negedge clk);
    chk("trig0_last", trig, 1);
    @(negedge clk);
    chk("trig0_dropped", trig, 0);
    wait_quiet(2000);
    chk_res(0, 0, 5, 0);
    chk_res(1, 1, 2, 0);
    chk("busy_end", busy, 0);

    // no echo on ch0, ch1 width 8
    log_q.delete();
    forced_d = {-1, 3}; forced_h = {0, 8};
    start_scan();
    wait_quiet(2000);
    chk_res(0, 0, 0, 1);
    chk_res(1, 1, 2, 0);

    // stuck-high echo0
    log_q.delete();
    forced_d = {2, 1}; forced_h = {100, 7};
    start_scan();
    wait_quiet(2000);
    rise0 = rise_at[0];
    chk_res(0, 0, 10, 1);
    chk_res(1, 1, 1, 0);
    if (log_q.size() > 0) chk("sat_latency", log_q[0].at - (rise0 + 3), 40);

    // width boundary, with start pulses while busy
    log_q.delete();
    forced_d = {0, 0}; forced_h = {8, 7};
    start_scan();
    repeat (5) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_quiet(2000);
    chk_res(0, 0, 2, 0);
    chk_res(1, 1, 1, 0);
    chk("boundary_count", log_q.size(), 2);

    // randomized continuous scanning
    log_q.delete();
    continuous = 1'b1;
    start_scan();
    n = 0;
    while (log_q.size() < 40 && n < 20000) begin
      @(negedge clk); n++;
      start = (busy && $urandom_range(0, 15) == 0);
    end
    start = 1'b0;
    n = 0;
    while (!(result_valid && result_ch == 0) && n < 2000) begin @(negedge clk); n++; end
    continuous = 1'b0;
    wait_quiet(4000);
    chk("random_enough_results", log_q.size() >= 40, 1);

    // reset mid-MEASURE
    forced_d = {0}; forced_h = {30};
    start_scan();
    n = 0;
    while (!echo[0] && n < 200) begin @(negedge clk); n++; end
    chk("echo0_seen", echo[0], 1);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    rst_n = 1'b1;
    forced_d.delete(); forced_h.delete();
    repeat (5) @(negedge clk);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_valid", result_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ultrasonic_array.md
# ultrasonic_array

Multi-channel ultrasonic ranging controller: drives trigger pulses to NCH sensors in round-robin, measures each echo pulse width in units of CONSTANT clock cycles, and reports one result per channel with a timeout flag. It is the parametrised successor of the single-channel echo counter. It adds trigger generation, input synchronisation, echo/no-echo timeouts, an inter-channel holdoff and a continuous-scan mode. It sits between the sensor pins and the SoC register interface.

## Interface
- NCH, 4: number of sensor channels (≥1)
- N, 16: width of the distance value
- CONSTANT, 588: clock cycles per distance unit (≥2)
- TRIG_CYCLES, 500: trigger pulse length in clk cycles (≥1)
- WAIT_UNITS, 50: max units waiting for echo rise before timeout (≥1)
- MAX_UNITS, 400: measured value saturation/timeout limit (≥1, < 2^N)
- GAP_CYCLES, 1000: holdoff between channels in clk cycles (≥1)
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a scan at channel 0; ignored while busy
- continuous  in  1  when 1, scan restarts at channel 0 after last channel
- echo  in  NCH  raw asynchronous echo inputs
- trig  out  NCH  one-hot trigger outputs
- busy  out  1  high whenever state ≠ IDLE
- result_valid  out  1  one-cycle pulse per completed channel
- result_ch  out  CW  channel of current result, CW = max(1, clog2(NCH))
- result_value  out  N  distance in units
- result_timeout  out  1  result is a timeout/saturation

## Operation
- echo passes through a 2-flop synchroniser per channel (echo_s); only the selected channel is used.
- Prescaler pre counts 0..CONSTANT-1; a unit tick occurs when pre == CONSTANT-1 (pre wraps to 0). pre clears on every state entry.
- States: IDLE, TRIG, WAIT_ECHO, MEASURE, REPORT, HOLD.
- IDLE: ch=0. start=1 -> TRIG.
- TRIG: trig[ch]=1 for exactly TRIG_CYCLES cycles -> WAIT_ECHO.
- WAIT_ECHO: echo_s[ch]=1 -> MEASURE (value cleared). If WAIT_UNITS unit ticks elapse first -> REPORT with value=0 and timeout=1.
- MEASURE: each unit tick increments value. echo_s[ch]=0 -> REPORT, timeout=0. If value reaches MAX_UNITS -> REPORT with value=MAX_UNITS and timeout=1, whatever echo does. The result is floor(H/CONSTANT), where H is the echo-high width in cycles.
- REPORT (1 cycle): result_valid=1. result_ch/value/timeout update in this cycle and hold until the next REPORT -> HOLD.
- HOLD: GAP_CYCLES cycles, then:
  - ch < NCH-1: ch+1, -> TRIG.
  - ch = NCH-1 and continuous=1: ch=0, -> TRIG.
  - otherwise: -> IDLE.
- A stuck-high echo yields MAX_UNITS with timeout=1. No value arithmetic wraps.
- continuous is sampled only at the HOLD exit of the last channel.

## Timing
- Reset: all outputs 0, state IDLE, ch=0, pre=0, synchroniser flops 0. Reset mid-scan drops trig at the next edge; no result is emitted.
- start sampled high at edge k: busy and trig[0] are high from k+1, and trig falls at k+1+TRIG_CYCLES.
- Echo edges reach FSM decisions 2 cycles late (synchroniser). Rise and fall are delayed equally, so width is preserved.
- Echo fall seen in MEASURE at edge m: result_valid is high in cycle m+1, values are stable from m+1, and HOLD starts at m+2.
- start during busy: no effect. start and reset together: reset wins.
- Echo on unselected channels is ignored.

## Test plan
- NCH=2, CONSTANT=4, TRIG_CYCLES=3, GAP=2, MAX=10, WAIT=5. Pulse start, echo0 high 20 cycles, echo1 high 9 cycles -> trig0 3 cycles, then results (ch0, 5, 0) and (ch1, 2, 0), then IDLE with busy=0.
- Channel 0 never echoes -> after 5×4=20 WAIT_ECHO cycles, result (ch0, 0, timeout=1), then trig1 follows.
- echo0 held high for 100 cycles -> result (ch0, 10, timeout=1) exactly 40 cycles after MEASURE entry.
- continuous=1 -> after ch1 HOLD, trig0 reasserts with no start pulse. Clear continuous -> IDLE after the next ch1.
- Assert rst_n=0 mid-MEASURE -> next edge: trig=0, busy=0, result_valid=0, outputs 0. start pulses during busy are ignored.
- Boundary: echo width exactly 8 cycles -> value 2, width 7 -> value 1 (CONSTANT=4).
